// File: rtl/if_prefetch_queue_if.sv
// Bus between the instruction-fetch prefetch queue, the instruction SRAM and ID.
// The master side is the prefetch queue; the slave side is the SRAM/ID environment.
interface if_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_rdata;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              id_allow_in;
  logic              if_to_id_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic [CNT_W-1:0]  queue_count;

  modport master (
    output inst_sram_en, inst_sram_addr, if_to_id_valid, if_pc, if_inst, queue_count,
    input  inst_sram_rdata, br_taken, br_target, id_allow_in
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr, if_to_id_valid, if_pc, if_inst, queue_count,
    output inst_sram_rdata, br_taken, br_target, id_allow_in
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetches to a synchronous-read
// SRAM, buffers returned instructions in a DEPTH-entry FIFO and hands them to ID.
// A taken branch from ID flushes buffered and in-flight fetches and redirects fpc.
module if_prefetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c000000,
  parameter int              CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  if_prefetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_q;
  logic              kill_q;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic             valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   credit;

  // Handshake, push/pop and the credit check that reserves a slot per in-flight request.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; otherwise a latch is inferred.
    valid  = 1'b0;
    pop    = 1'b0;
    push   = 1'b0;
    credit = '0;
    issue  = 1'b0;

    valid  = resetn & (count != '0) & ~bus.br_taken;
    pop    = valid & bus.id_allow_in;
    push   = req_q & ~bus.br_taken & ~kill_q;
    credit = {1'b0, count} + {{CNT_W{1'b0}}, req_q} - {{CNT_W{1'b0}}, pop};
    issue  = resetn & ~bus.br_taken & (credit < (CNT_W+1)'(DEPTH));
  end

  // Fetch PC, request tracking, pointers and occupancy; flush wins over everything but reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!resetn) begin
      fpc    <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_q  <= 1'b0;
      kill_q <= 1'b0;
    end else if (bus.br_taken) begin
      fpc    <= bus.br_target;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_q  <= 1'b0;
      kill_q <= req_q;
    end else begin
      req_q  <= issue;
      kill_q <= 1'b0;
      if (issue) begin
        req_pc_q <= fpc;
        fpc      <= fpc + ADDR_W'(4);
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage: the pc travels with the returned instruction word.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count and the pointers alone decide which entries are live.
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc_q;
      inst_mem[wr_ptr] <= bus.inst_sram_rdata;
    end
  end

  assign bus.inst_sram_en   = issue;
  assign bus.inst_sram_addr = fpc;
  assign bus.if_to_id_valid = valid;
  assign bus.if_pc          = pc_mem[rd_ptr];
  assign bus.if_inst        = inst_mem[rd_ptr];
  assign bus.queue_count    = resetn ? count : '0;

`ifndef SYNTHESIS
  // The credit check must make a push into a full queue impossible.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!resetn) !(push && (count == CNT_W'(DEPTH)))
  ) else $error("prefetch queue: push while full");
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed flows on a DEPTH=4 queue plus two
// randomly throttled queues (DEPTH=2, DEPTH=8). The SRAM models return the
// address as data, so every delivered instruction must equal its pc.
module tb_if_prefetch_queue;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic clk = 1'b0;
  logic resetn;
  logic resetn_r;

  always #5 clk = ~clk;

  if_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();
  if_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) r2  ();
  if_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) r8  ();

  if_prefetch_queue #(.DEPTH(4)) dut    (.clk(clk), .resetn(resetn),   .bus(bus));
  if_prefetch_queue #(.DEPTH(2)) dut_d2 (.clk(clk), .resetn(resetn_r), .bus(r2));
  if_prefetch_queue #(.DEPTH(8)) dut_d8 (.clk(clk), .resetn(resetn_r), .bus(r8));

  // Synchronous-read SRAM models: data = address, one cycle after the request.
  always @(posedge clk) if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr;
  always @(posedge clk) if (r2.inst_sram_en)  r2.inst_sram_rdata  <= r2.inst_sram_addr;
  always @(posedge clk) if (r8.inst_sram_en)  r8.inst_sram_rdata  <= r8.inst_sram_addr;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] nxt2 = RST_PC;
  logic [31:0] nxt8 = RST_PC;
  int          n2 = 0;
  int          n8 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: pops the scoreboard on every accepted hand-off of the DEPTH=4 queue
  // and tracks the strictly sequential streams of the random queues.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      check("m_count_le_depth", 64'(bus.queue_count <= 3'd4), 1);
      if (bus.if_to_id_valid && bus.id_allow_in) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL m_unexpected_pop: got pc %0h, expected no delivery (t=%0t)", bus.if_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("m_pop_pc",   bus.if_pc,   e);
          check("m_pop_inst", bus.if_inst, e);
        end
      end
      if (resetn_r) begin
        check("d2_count_le_depth", 64'(r2.queue_count <= 2'd2), 1);
        check("d8_count_le_depth", 64'(r8.queue_count <= 4'd8), 1);
        if (r2.if_to_id_valid && r2.id_allow_in) begin
          check("d2_pc",   r2.if_pc,   nxt2);
          check("d2_inst", r2.if_inst, nxt2);
          nxt2 += 32'd4;
          n2++;
        end
        if (r8.if_to_id_valid && r8.id_allow_in) begin
          check("d8_pc",   r8.if_pc,   nxt8);
          check("d8_inst", r8.if_inst, nxt8);
          nxt8 += 32'd4;
          n8++;
        end
      end
    end
  endtask

  // Random throttling of ID on the DEPTH=2 and DEPTH=8 queues.
  task automatic rand_seq();
    resetn_r = 1'b0;
    r2.id_allow_in = 1'b0;
    r8.id_allow_in = 1'b0;
    tick();
    tick();
    resetn_r = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r2.id_allow_in = 1'($urandom_range(0, 1));
      r8.id_allow_in = 1'($urandom_range(0, 1));
      tick();
    end
    r2.id_allow_in = 1'b0;
    r8.id_allow_in = 1'b0;
  endtask

  // Directed flows on the DEPTH=4 queue.
  task automatic main_seq();
    resetn = 1'b0;
    bus.id_allow_in = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    tick(); settle();
    check("rst_en",    bus.inst_sram_en,   0);
    check("rst_valid", bus.if_to_id_valid, 0);
    check("rst_count", bus.queue_count,    0);

    // Stream from reset, one ID stall, then a flush with count=2 and a request in flight.
    tick(); resetn = 1'b1;                               // cycle 0
    exp_q.push_back(32'h1c000000); exp_q.push_back(32'h1c000004);
    exp_q.push_back(32'h1c000008); exp_q.push_back(32'h1c00000c);
    exp_q.push_back(32'h1c000010);
    settle();
    check("a_c0_en",    bus.inst_sram_en,   1);
    check("a_c0_addr",  bus.inst_sram_addr, 32'h1c000000);
    check("a_c0_valid", bus.if_to_id_valid, 0);
    tick(); settle();                                    // cycle 1
    check("a_c1_valid", bus.if_to_id_valid, 0);
    check("a_c1_addr",  bus.inst_sram_addr, 32'h1c000004);
    tick(); settle();                                    // cycle 2
    check("a_c2_valid", bus.if_to_id_valid, 1);
    for (int i = 0; i < 4; i++) tick();                  // cycle 6
    bus.id_allow_in = 1'b0;
    tick(); bus.id_allow_in = 1'b1;                      // cycle 7
    tick(); settle();                                    // cycle 8
    check("c_pre_count", bus.queue_count, 2);
    bus.br_taken = 1'b1; bus.br_target = 32'h1c000100;
    settle();
    check("c_br_valid", bus.if_to_id_valid, 0);
    check("c_br_en",    bus.inst_sram_en,   0);
    tick(); bus.br_taken = 1'b0;                         // cycle 9
    exp_q.push_back(32'h1c000100);
    settle();
    check("c_flush_count", bus.queue_count,    0);
    check("c_tgt_en",      bus.inst_sram_en,   1);
    check("c_tgt_addr",    bus.inst_sram_addr, 32'h1c000100);
    tick(); settle();                                    // cycle 10
    check("c_c10_valid", bus.if_to_id_valid, 0);
    tick(); settle();                                    // cycle 11
    check("c_c11_valid", bus.if_to_id_valid, 1);

    // Two consecutive branches: only the second target is fetched.
    tick(); bus.br_taken = 1'b1; bus.br_target = 32'h1c000200;   // cycle 12
    settle();
    check("d_br1_en",    bus.inst_sram_en,   0);
    check("d_br1_valid", bus.if_to_id_valid, 0);
    tick(); bus.br_target = 32'h1c000300;                        // cycle 13
    settle();
    check("d_br2_en", bus.inst_sram_en, 0);
    tick(); bus.br_taken = 1'b0;                                 // cycle 14
    exp_q.push_back(32'h1c000300); exp_q.push_back(32'h1c000304);
    exp_q.push_back(32'h1c000308);
    settle();
    check("d_tgt_en",   bus.inst_sram_en,   1);
    check("d_tgt_addr", bus.inst_sram_addr, 32'h1c000300);
    for (int i = 0; i < 5; i++) tick();                          // cycle 19

    // Reset with ID stalled: exactly DEPTH requests, then drain.
    resetn = 1'b0; bus.id_allow_in = 1'b0;
    settle();
    check("b_rst_valid", bus.if_to_id_valid, 0);
    check("b_rst_count", bus.queue_count,    0);
    check("b_rst_en",    bus.inst_sram_en,   0);
    tick(); tick(); resetn = 1'b1;                               // b0
    exp_q.push_back(32'h1c000000); exp_q.push_back(32'h1c000004);
    exp_q.push_back(32'h1c000008); exp_q.push_back(32'h1c00000c);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("b_fill_en",   bus.inst_sram_en,   1);
      check("b_fill_addr", bus.inst_sram_addr, 32'h1c000000 + 32'(4 * i));
      tick();
    end
    settle();                                                    // b4
    check("b_c4_en", bus.inst_sram_en, 0);
    tick(); settle();                                            // b5
    check("b_full_en",    bus.inst_sram_en, 0);
    check("b_full_count", bus.queue_count,  4);
    tick(); bus.id_allow_in = 1'b1;                              // b6
    settle();
    check("b_resume_valid", bus.if_to_id_valid, 1);
    check("b_resume_en",    bus.inst_sram_en,   1);
    check("b_resume_addr",  bus.inst_sram_addr, 32'h1c000010);
    for (int i = 0; i < 4; i++) tick();                          // b10
    settle();
    check("f_pre_count", bus.queue_count, 3);

    // One-cycle reset in the middle of the stream.
    resetn = 1'b0;
    settle();
    check("f_rst_valid", bus.if_to_id_valid, 0);
    tick(); resetn = 1'b1;                                       // b11
    exp_q.push_back(32'h1c000000); exp_q.push_back(32'h1c000004);
    exp_q.push_back(32'h1c000008);
    settle();
    check("f_post_valid", bus.if_to_id_valid, 0);
    check("f_post_count", bus.queue_count,    0);
    check("f_post_en",    bus.inst_sram_en,   1);
    check("f_post_addr",  bus.inst_sram_addr, 32'h1c000000);
    for (int i = 0; i < 5; i++) tick();                          // b16

    // Unaligned branch target close to the top of the address space: low bits pass, pc wraps.
    bus.br_taken = 1'b1; bus.br_target = 32'hfffffffe;
    settle();
    check("w_br_valid", bus.if_to_id_valid, 0);
    tick(); bus.br_taken = 1'b0;                                 // b17
    exp_q.push_back(32'hfffffffe); exp_q.push_back(32'h00000002);
    settle();
    check("w_tgt_addr", bus.inst_sram_addr, 32'hfffffffe);
    tick(); settle();                                            // b18
    check("w_wrap_en",   bus.inst_sram_en,   1);
    check("w_wrap_addr", bus.inst_sram_addr, 32'h00000002);
    tick(); tick(); tick();                                      // b21
    bus.id_allow_in = 1'b0;
    tick(); settle();
    check("m_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    r2.br_taken = 1'b0; r2.br_target = '0;
    r8.br_taken = 1'b0; r8.br_target = '0;
    resetn   = 1'b0;
    resetn_r = 1'b0;
    fork
      monitor();
    join_none
    fork
      main_seq();
      rand_seq();
    join
    @(negedge clk);
    #1;
    check("d2_progress", 64'(n2 > 100), 1);
    check("d8_progress", 64'(n8 > 100), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
